// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- single-entry LoongArch32 decode stage
//
// Holds one fetched {pc, inst} pair and turns it into an execute bus. It
// reads the register file combinationally, resolves branches and redirects
// fetch. After every taken branch it throws away exactly one wrong-path
// instruction.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   in_valid / in_ready      handshake from fetch
//   in_bus[63:0]             {pc[31:0], inst[31:0]}
//   rf_raddr1/2, rf_rdata1/2 combinational register-file read
//   out_valid / out_ready    handshake to execute
//   out_bus[140:0]           {pc, alu_op[3:0], src1, src2, st_data, dest[4:0],
//                             rf_we, mem_re, mem_we, ine}
//   br_taken, br_target      redirect to fetch
//
// Build option
//   ID_INST_CHECK_EN  when defined, ine (out_bus[0]) flags unrecognised
//                     encodings. Those encodings still behave as a NOP.
//                     When undefined, ine is tied to 0.
// ---------------------------------------------------------------------------
module id_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [140:0] out_bus,
  output logic         br_taken,
  output logic [31:0]  br_target
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_NOR   = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_PASS2 = 4'd11;

  logic        id_valid;
  logic        drop_pending;
  logic [63:0] id_bus;

  logic        in_fire;
  logic        out_fire;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rd;
  logic [4:0]  rj;
  logic [4:0]  rk;
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;

  assign pc   = id_bus[63:32];
  assign inst = id_bus[31:0];
  assign rd   = inst[4:0];
  assign rj   = inst[9:5];
  assign rk   = inst[14:10];
  assign op17 = inst[31:15];
  assign op10 = inst[31:22];
  assign op7  = inst[31:25];
  assign op6  = inst[31:26];

  // Instruction-class decode
  logic op_3r, op_sh, is_addi, is_ld, is_st, is_lu12i;
  logic is_jirl, is_b, is_bl, is_beq, is_bne;

  assign op_3r    = op17 inside {17'h00020, 17'h00022, 17'h00024, 17'h00025,
                                 17'h00028, 17'h00029, 17'h0002A, 17'h0002B};
  assign op_sh    = op17 inside {17'h00081, 17'h00089, 17'h00091};
  assign is_addi  = (op10 == 10'h00A);
  assign is_ld    = (op10 == 10'h0A2);
  assign is_st    = (op10 == 10'h0A6);
  assign is_lu12i = (op7  == 7'h0A);
  assign is_jirl  = (op6  == 6'h13);
  assign is_b     = (op6  == 6'h14);
  assign is_bl    = (op6  == 6'h15);
  assign is_beq   = (op6  == 6'h16);
  assign is_bne   = (op6  == 6'h17);

  // Stores and compare-branches need rd's value on the second read port
  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_st | is_beq | is_bne) ? rd : rk;

  logic [31:0] simm12;
  logic [31:0] offs16;
  logic [31:0] offs26;

  assign simm12 = {{20{inst[21]}}, inst[21:10]};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  logic [3:0]  alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  dest;
  logic        wr_type;
  logic        mem_re;
  logic        mem_we;
  logic        rf_we;
  logic        ine;

  always_comb begin
    alu_op  = ALU_ADD;
    src1    = rf_rdata1;
    src2    = rf_rdata2;
    dest    = 5'd0;
    wr_type = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    if (op_3r) begin
      dest    = rd;
      wr_type = 1'b1;
      case (op17[3:0])
        4'h0:    alu_op = ALU_ADD;
        4'h2:    alu_op = ALU_SUB;
        4'h4:    alu_op = ALU_SLT;
        4'h5:    alu_op = ALU_SLTU;
        4'h8:    alu_op = ALU_NOR;
        4'h9:    alu_op = ALU_AND;
        4'hA:    alu_op = ALU_OR;
        default: alu_op = ALU_XOR;
      endcase
    end else if (op_sh) begin
      dest    = rd;
      wr_type = 1'b1;
      src2    = {27'd0, inst[14:10]};
      case (op17[4:3])
        2'b00:   alu_op = ALU_SLL;
        2'b01:   alu_op = ALU_SRL;
        default: alu_op = ALU_SRA;
      endcase
    end else if (is_addi | is_ld | is_st) begin
      src2    = simm12;
      mem_re  = is_ld;
      mem_we  = is_st;
      wr_type = ~is_st;
      dest    = is_st ? 5'd0 : rd;
    end else if (is_lu12i) begin
      alu_op  = ALU_PASS2;
      src2    = {inst[24:5], 12'd0};
      dest    = rd;
      wr_type = 1'b1;
    end else if (is_jirl | is_bl) begin
      // Link value pc+4 is formed by the execute ALU
      src1    = pc;
      src2    = 32'd4;
      dest    = is_bl ? 5'd1 : rd;
      wr_type = 1'b1;
    end
  end

  // Writes to r0 are squashed here so execute never has to check
  assign rf_we = wr_type & (dest != 5'd0);

`ifdef ID_INST_CHECK_EN
  logic known;
  assign known = op_3r | op_sh | is_addi | is_ld | is_st | is_lu12i |
                 is_jirl | is_b | is_bl | is_beq | is_bne;
  assign ine   = ~known;
`else
  assign ine   = 1'b0;
`endif

  // Branch resolution
  logic br_cond;
  assign br_cond = is_b | is_bl | is_jirl |
                   (is_beq & (rf_rdata1 == rf_rdata2)) |
                   (is_bne & (rf_rdata1 != rf_rdata2));

  always_comb begin
    if (is_b | is_bl)
      br_target = pc + offs26;
    else if (is_jirl)
      br_target = rf_rdata1 + offs16;
    else
      br_target = pc + offs16;
  end

  // Handshake
  assign out_valid = id_valid;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~id_valid | out_fire;
  assign in_fire   = in_valid & in_ready;
  assign br_taken  = out_fire & br_cond;

  assign out_bus = {pc, alu_op, src1, src2, rf_rdata2, dest,
                    rf_we, mem_re, mem_we, ine};

  // An instruction accepted in the same cycle as a taken branch, or the
  // first one accepted after it, is on the wrong path and is not kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid     <= 1'b0;
      drop_pending <= 1'b0;
      id_bus       <= 64'd0;
    end else begin
      if (in_fire) begin
        drop_pending <= 1'b0;
        if (br_taken || drop_pending) begin
          id_valid <= 1'b0;
        end else begin
          id_valid <= 1'b1;
          id_bus   <= in_bus;
        end
      end else begin
        if (out_fire)
          id_valid <= 1'b0;
        if (br_taken)
          drop_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage
//
// A reference model predicts the handshake, decode bus and branch outputs
// from instruction semantics; a negedge process compares every cycle.
// Directed sequences add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_bus = 64'd0;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [140:0] out_bus;
  logic         br_taken;
  logic [31:0]  br_target;

  int errors = 0;
  int checks = 0;

`ifdef ID_INST_CHECK_EN
  localparam bit INE_EN = 1'b1;
`else
  localparam bit INE_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  id_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .br_taken  (br_taken),
    .br_target (br_target)
  );

  task automatic chk(input string nm, input logic [140:0] act, input logic [140:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int K_NOP = 0, K_3R = 1, K_SH = 2, K_ADDI = 3, K_LD = 4, K_ST = 5,
                 K_LU = 6, K_JIRL = 7, K_B = 8, K_BL = 9, K_BEQ = 10, K_BNE = 11;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] s1, s2, std;
    logic [4:0]  dst;
    logic        we, re, wm, ine, isbr, tk;
    logic [31:0] tgt;
    logic [4:0]  a1, a2;
  } dec_t;

  function automatic dec_t model(input logic [31:0] pc, input logic [31:0] inst);
    dec_t d;
    logic [4:0] rd, rj, rk;
    logic signed [11:0] i12;
    logic signed [15:0] i16;
    logic signed [25:0] i26;
    int imm, off16, off26, k;
    logic [3:0] aop;
    logic [31:0] v1, v2;
    rd = inst[4:0]; rj = inst[9:5]; rk = inst[14:10];
    i12 = inst[21:10]; i16 = inst[25:10]; i26 = {inst[9:0], inst[25:10]};
    imm = int'(i12); off16 = int'(i16) * 4; off26 = int'(i26) * 4;
    k = K_NOP; aop = 4'd0;
    case (inst[31:15])
      17'h20: begin k = K_3R; aop = 4'd0;  end
      17'h22: begin k = K_3R; aop = 4'd1;  end
      17'h24: begin k = K_3R; aop = 4'd2;  end
      17'h25: begin k = K_3R; aop = 4'd3;  end
      17'h28: begin k = K_3R; aop = 4'd7;  end
      17'h29: begin k = K_3R; aop = 4'd4;  end
      17'h2A: begin k = K_3R; aop = 4'd5;  end
      17'h2B: begin k = K_3R; aop = 4'd6;  end
      17'h81: begin k = K_SH; aop = 4'd8;  end
      17'h89: begin k = K_SH; aop = 4'd9;  end
      17'h91: begin k = K_SH; aop = 4'd10; end
      default: ;
    endcase
    if (k == K_NOP) begin
      case (inst[31:22])
        10'h00A: k = K_ADDI;
        10'h0A2: k = K_LD;
        10'h0A6: k = K_ST;
        default: ;
      endcase
    end
    if (k == K_NOP && inst[31:25] == 7'h0A) k = K_LU;
    if (k == K_NOP) begin
      case (inst[31:26])
        6'h13: k = K_JIRL;
        6'h14: k = K_B;
        6'h15: k = K_BL;
        6'h16: k = K_BEQ;
        6'h17: k = K_BNE;
        default: ;
      endcase
    end
    d = '0;
    d.a1 = rj;
    d.a2 = (k == K_ST || k == K_BEQ || k == K_BNE) ? rd : rk;
    v1 = rf[d.a1]; v2 = rf[d.a2];
    d.alu = aop; d.s1 = v1; d.s2 = v2; d.std = v2;
    case (k)
      K_3R:   begin d.dst = rd; d.we = 1'b1; end
      K_SH:   begin d.dst = rd; d.we = 1'b1; d.s2 = 32'(rk); end
      K_ADDI: begin d.dst = rd; d.we = 1'b1; d.s2 = imm; end
      K_LD:   begin d.dst = rd; d.we = 1'b1; d.re = 1'b1; d.s2 = imm; end
      K_ST:   begin d.wm = 1'b1; d.s2 = imm; end
      K_LU:   begin d.dst = rd; d.we = 1'b1; d.alu = 4'd11; d.s2 = {inst[24:5], 12'h000}; end
      K_JIRL: begin d.s1 = pc; d.s2 = 32'd4; d.dst = rd; d.we = 1'b1; d.tk = 1'b1; d.tgt = v1 + off16; end
      K_BL:   begin d.s1 = pc; d.s2 = 32'd4; d.dst = 5'd1; d.we = 1'b1; d.tk = 1'b1; d.tgt = pc + off26; end
      K_B:    begin d.tk = 1'b1; d.tgt = pc + off26; end
      K_BEQ:  begin d.tk = (v1 == v2); d.tgt = pc + off16; end
      K_BNE:  begin d.tk = (v1 != v2); d.tgt = pc + off16; end
      default: ;
    endcase
    if (d.dst == 5'd0) d.we = 1'b0;
    d.isbr = (k >= K_JIRL);
    d.ine  = INE_EN && (k == K_NOP);
    return d;
  endfunction

  logic        m_valid, m_drop;
  logic [31:0] m_pc, m_inst;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_drop <= 1'b0; m_pc <= 32'd0; m_inst <= 32'd0;
    end else begin
      dec_t d;
      logic go_out, go_in, redirect, keep;
      d        = model(m_pc, m_inst);
      go_out   = m_valid && out_ready;
      redirect = go_out && d.tk;
      go_in    = in_valid && (!m_valid || out_ready);
      keep     = go_in && !redirect && !m_drop;
      m_valid  <= keep || (m_valid && !go_out);
      if (keep) begin
        m_pc   <= in_bus[63:32];
        m_inst <= in_bus[31:0];
      end
      m_drop   <= go_in ? 1'b0 : (m_drop || redirect);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      dec_t d;
      d = model(m_pc, m_inst);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("br_taken", br_taken, m_valid && out_ready && d.tk);
      if (m_valid) begin
        chk("out_bus", out_bus, {m_pc, d.alu, d.s1, d.s2, d.std, d.dst, d.we, d.re, d.wm, d.ine});
        chk("rf_raddr1", rf_raddr1, d.a1);
        chk("rf_raddr2", rf_raddr2, d.a2);
        if (d.isbr) chk("br_target", br_target, d.tgt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    in_valid  = v;
    in_bus    = {pc, inst};
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h00101884; // add.w r4,r4,r6
  localparam logic [31:0] I_SUB  = 32'h00111885; // sub.w r5,r4,r6
  localparam logic [31:0] I_XOR  = 32'h0015988D; // xor r13,r4,r6
  localparam logic [31:0] I_BEQ  = 32'h58001022; // beq r1,r2,+16
  localparam logic [31:0] I_BL   = 32'h54002000; // bl +32

  logic [31:0] flow [16] = '{
    32'h00408C87, // slli.w r7,r4,3
    32'h0048FD28, // srai.w r8,r9,31
    32'h02BFFC8A, // addi.w r10,r4,-1
    32'h2880208B, // ld.w r11,r4,8
    32'h29803086, // st.w r6,r4,12
    32'h142468AC, // lu12i.w r12,0x12345
    32'h00101880, // add.w r0,r4,r6
    32'h5C001022, // bne r1,r2 (not taken)
    32'h4C000881, // jirl r1,r4,8
    32'h0014188E, // nor (wrong path)
    32'h50000400, // b +4
    32'h0012988F, // sltu (wrong path)
    32'h00151890, // or
    32'h00149891, // and
    32'h00121892, // slt
    32'h00449133  // srli.w r19,r9,4
  };

  logic [140:0] held;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'd0; rf[1] = 32'd3; rf[2] = 32'd3; rf[4] = 32'd5; rf[6] = 32'd7;
    rf[9] = 32'h8000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_br_taken", br_taken, 0);
    reset = 1'b0;

    // add.w r4,r4,r6
    put(1, 32'h1C000000, I_ADD, 1); tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("add_valid", out_valid, 1);
    chk("add_alu", out_bus[108:105], 0);
    chk("add_src1", out_bus[104:73], 5);
    chk("add_src2", out_bus[72:41], 7);
    chk("add_dest", out_bus[8:4], 4);
    chk("add_we", out_bus[3], 1);
    tick();

    // Back-pressure: three stalled cycles
    put(1, 32'h1C000004, I_SUB, 0); tick();
    put(1, 32'h1C000008, I_XOR, 0); #1;
    held = out_bus;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_bus", out_bus, held);
      chk("stall_pc", out_bus[140:109], 32'h1C000004);
      tick();
    end
    out_ready = 1'b1; tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("stall_next_pc", out_bus[140:109], 32'h1C000008);
    tick();

    // Mixed flow with one stall, a jirl and a b
    for (int i = 0; i < 16; i++) begin
      put(1, 32'h1C000040 + 32'(i) * 4, flow[i], i != 5);
      tick();
    end
    put(0, 32'd0, 32'd0, 1); tick(); tick();

    // beq taken with a wrong-path fetch in the same cycle
    put(1, 32'h1C000010, I_BEQ, 1); tick();
    put(1, 32'h1C000014, I_ADD, 1); #1;
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h1C000020);
    tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("beq_drop", out_valid, 0);
    tick();

    // bl taken with nothing fetched that cycle
    put(1, 32'h1C000100, I_BL, 1); tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("bl_taken", br_taken, 1);
    chk("bl_target", br_target, 32'h1C000120);
    chk("bl_dest", out_bus[8:4], 1);
    chk("bl_src1", out_bus[104:73], 32'h1C000100);
    chk("bl_src2", out_bus[72:41], 4);
    chk("bl_we", out_bus[3], 1);
    tick();
    put(1, 32'h1C000120, I_SUB, 1); tick();
    put(1, 32'h1C000124, I_XOR, 1); #1;
    chk("bl_dropped", out_valid, 0);
    tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("bl_after_valid", out_valid, 1);
    chk("bl_after_pc", out_bus[140:109], 32'h1C000124);
    tick();

    // Unrecognised encoding
    put(1, 32'h1C000200, 32'hFFFFFFFF, 1); tick();
    put(0, 32'd0, 32'd0, 1); #1;
    chk("ine_flags", out_bus[3:1], 0);
    chk("ine_bit", out_bus[0], INE_EN);
    chk("ine_br", br_taken, 0);
    tick();

    // Reset while holding a stalled instruction
    put(1, 32'h1C000300, I_ADD, 0); tick();
    put(0, 32'd0, 32'd0, 0); #1;
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1; #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  in  1  fetch holds a valid {pc,inst}.
REQ-004 SHALL have port in_ready  out  1  decode can accept this cycle.
REQ-005 SHALL have port in_bus  in  64  [63:32] pc, [31:0] inst.
REQ-006 SHALL have ports rf_raddr1/rf_raddr2  out  5 each, and rf_rdata1/rf_rdata2  in  32 each: combinational regfile read.
REQ-007 SHALL have port out_valid  out  1  decode bus valid to execute.
REQ-008 SHALL have port out_ready  in  1  execute allowin.
REQ-009 SHALL have port out_bus  out  141  [140:109] pc, [108:105] alu_op, [104:73] src1, [72:41] src2, [40:9] st_data, [8:4] dest, [3] rf_we, [2] mem_re, [1] mem_we, [0] ine.
REQ-010 SHALL have ports br_taken  out  1  and br_target  out  32: redirect to fetch.

Function
REQ-011 SHALL hold one instruction in registers id_valid, id_bus (64 b); out_fire = out_valid & out_ready; in_fire = in_valid & in_ready.
REQ-012 SHALL drive in_ready = ~id_valid | out_fire (combinational, no bubble on back-to-back flow).
REQ-013 SHALL on in_fire load id_bus <= in_bus, id_valid <= 1, unless the drop rule (REQ-019) discards it; on out_fire without in_fire, id_valid <= 0; otherwise hold.
REQ-014 SHALL decode LoongArch32 fields rd=inst[4:0], rj=inst[9:5], rk=inst[14:10]; rf_raddr1=rj; rf_raddr2=rk for 3R ops, rd for st.w/beq/bne.
REQ-015 SHALL support: add.w/sub.w/slt/sltu/nor/and/or/xor (inst[31:15]=0x00020/22/24/25/28/29/2A/2B), slli.w/srli.w/srai.w (0x00081/89/91, ui5), addi.w/ld.w/st.w (inst[31:22]=0x00A/0A2/0A6, si12 sign-extended), lu12i.w (inst[31:25]=0x0A, src2={si20,12'b0}), jirl/b/bl/beq/bne (inst[31:26]=0x13/14/15/16/17).
REQ-016 SHALL encode alu_op 0 ADD,1 SUB,2 SLT,3 SLTU,4 AND,5 OR,6 XOR,7 NOR,8 SLL,9 SRL,10 SRA,11 PASS2; ld.w/st.w use ADD with mem_re/mem_we set; st_data=rf_rdata2.
REQ-017 SHALL for bl: dest=1, jirl: dest=rd, both src1=pc, src2=4, ADD, rf_we=1; b/beq/bne/st.w rf_we=0; rf_we forced 0 when dest=0.
REQ-018 SHALL compute branch: offs16={{14{inst[25]}},inst[25:10],2'b0}, offs26={{4{inst[9]}},inst[9:0],inst[25:10],2'b0}; target pc+offs26 (b/bl), pc+offs16 (beq/bne), rj+offs16 (jirl); br_target driven combinationally; br_taken = out_fire & (b|bl|jirl|(beq & rj==rd-data)|(bne & rj!=rd-data)).
REQ-019 SHALL discard exactly one wrong-path instruction after each br_taken: if in_fire in the same cycle, it is not loaded (id_valid <= 0 unless otherwise held); else flag drop_pending <= 1 and the next in_fire is discarded and clears the flag; in_ready is unaffected by the flag.
REQ-020 SHALL drive out_valid = id_valid; out_bus combinational from id_bus and regfile data; outputs held stable while out_valid & ~out_ready.
REQ-021 SHALL treat unrecognised encodings as NOP (rf_we=mem_re=mem_we=0, no branch).

Reset
REQ-022 SHALL on reset asynchronously clear id_valid, drop_pending, id_bus to 0; out_valid=0, br_taken=0, in_ready=1 during and after reset until first in_fire.
REQ-023 SHALL discard an in-flight instruction and pending drop when reset asserts mid-operation.

Configuration
REQ-024 SHALL with ID_INST_CHECK_EN defined set out_bus[0] (ine) = 1 for unrecognised encodings while keeping NOP semantics; without it ine is constant 0 and no check logic exists.

Verification
REQ-025 SHALL cover: reset, then in_bus={0x1C000000,0x00101884} (add.w r4,r4,r6) with rdata1=5, rdata2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0, src1=5, src2=7, dest=4, rf_we=1.
REQ-026 SHALL cover: out_ready=0 for 3 cycles with id_valid=1 -> in_ready=0, out_bus stable, no second capture.
REQ-027 SHALL cover: beq at pc 0x1C000010, offs16=4, rj data=rd data=3, in_fire same cycle -> br_taken=1, br_target=0x1C000020, following instruction dropped, out_valid=0 next cycle.
REQ-028 SHALL cover: bl taken with in_valid=0 that cycle -> drop_pending=1, next accepted instruction discarded, the one after delivered; dest=1, src1=pc, src2=4.
REQ-029 SHALL cover: inst=0xFFFFFFFF -> no writes; ine=1 with ID_INST_CHECK_EN, 0 without.
REQ-030 SHALL cover: reset asserted while id_valid=1 and out_ready=0 -> out_valid=0 immediately, in_ready=1.
